// File: rtl/jtoutrun_subbus.sv
// jtoutrun_subbus
// Main-CPU-side initiator for the shared sub-CPU bus. When the main CPU selects
// the sub window, this block requests the bus and waits for the grant. It then
// runs one 16-bit access on the sub bus and returns the read data and an ack to
// the main CPU's DTACK logic. After an access it keeps the bus for a short
// time, so that back-to-back accesses skip re-arbitration. If the grant never
// comes, the request is aborted with a timeout pulse and all-ones read data.
//
// Ports
//   clk, rst         system clock; asynchronous active-high reset
//   cpu_cs           main CPU access to the sub window (held until cpu_ok)
//   cpu_A/dsn/rnw    main CPU address [19:1], {UDSn,LDSn}, read/not-write
//   cpu_dout         main CPU write data
//   cpu_din          read data returned to the main CPU
//   cpu_ok           access finished (held until cpu_cs drops)
//   timeout          one-cycle pulse when the grant wait is aborted
//   main_br          bus request to the sub CPU DMA arbiter
//   main_A/dsn/rnw   sub bus address, strobes (active low), direction
//   main_dout        sub bus write data (always the full word)
//   main_din         sub bus read data
//   main_ok          sub bus granted to us and not busy
// All outputs are registered.
module jtoutrun_subbus #(
  parameter int SETTLE = 2,    // cycles main_ok is ignored after strobes go out
  parameter int HOLD   = 16,   // idle cycles the bus is kept after an access
  parameter int TOUT   = 1023  // grant wait limit (cycles)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic [18:0] cpu_A,
  input  logic [1:0]  cpu_dsn,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_ok,
  output logic        timeout,
  output logic        main_br,
  output logic [18:0] main_A,
  output logic [1:0]  main_dsn,
  output logic        main_rnw,
  output logic [15:0] main_dout,
  input  logic [15:0] main_din,
  input  logic        main_ok
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACCESS, S_DONE, S_HOLD} state_t;

  // The counter compares against "last" values: the transition fires on the
  // N-th cycle spent in the state, because the counter is cleared on entry.
  localparam logic [9:0] SETTLE_W  = 10'(SETTLE);
  localparam logic [9:0] HOLD_LAST = 10'(HOLD - 1);
  localparam logic [9:0] TOUT_LAST = 10'(TOUT - 1);

  state_t      state_reg, state_next;
  logic [9:0]  cnt_reg, cnt_next;
  logic [1:0]  dsn_lat_reg, dsn_lat_next;  // strobes held back while waiting for grant
  logic        br_next, rnw_next, ok_next, tout_next;
  logic [18:0] a_next;
  logic [1:0]  dsn_next;
  logic [15:0] dout_next, din_next;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    dsn_lat_next = dsn_lat_reg;
    br_next      = main_br;
    a_next       = main_A;
    dsn_next     = main_dsn;
    rnw_next     = main_rnw;
    dout_next    = main_dout;
    din_next     = cpu_din;
    ok_next      = cpu_ok;
    tout_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cpu_cs) begin
          a_next       = cpu_A;
          rnw_next     = cpu_rnw;
          dout_next    = cpu_dout;
          dsn_lat_next = cpu_dsn;
          dsn_next     = 2'b11;
          br_next      = 1'b1;
          cnt_next     = '0;
          state_next   = S_REQ;
        end
      end
      S_REQ: begin
        dsn_next = 2'b11;
        if (!cpu_cs) begin
          // Main CPU gave up before the grant: withdraw quietly, no ack.
          br_next    = 1'b0;
          state_next = S_IDLE;
        end else if (main_ok) begin
          dsn_next   = dsn_lat_reg;
          cnt_next   = '0;
          state_next = S_ACCESS;
        end else if (cnt_reg == TOUT_LAST) begin
          din_next   = 16'hFFFF;
          tout_next  = 1'b1;
          ok_next    = 1'b1;
          br_next    = 1'b0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      S_ACCESS: begin
        // The sub side decodes chip selects through a register, so main_ok
        // may still reflect the previous cycle during the first SETTLE cycles.
        if (cnt_reg < SETTLE_W) begin
          cnt_next = cnt_reg + 10'd1;
        end else if (main_ok) begin
          if (main_rnw) din_next = main_din;
          dsn_next   = 2'b11;
          ok_next    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!cpu_cs) begin
          ok_next = 1'b0;
          if (main_br) begin
            cnt_next   = '0;
            state_next = S_HOLD;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        dsn_next = 2'b11;
        // A new request beats the hold expiry on the same cycle.
        if (cpu_cs) begin
          a_next       = cpu_A;
          rnw_next     = cpu_rnw;
          dout_next    = cpu_dout;
          dsn_lat_next = cpu_dsn;
          dsn_next     = cpu_dsn;
          cnt_next     = '0;
          state_next   = S_ACCESS;
        end else if (cnt_reg == HOLD_LAST) begin
          br_next    = 1'b0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      default: begin
        br_next    = 1'b0;
        dsn_next   = 2'b11;
        ok_next    = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      dsn_lat_reg <= 2'b11;
      main_br     <= 1'b0;
      main_A      <= '0;
      main_dsn    <= 2'b11;
      main_rnw    <= 1'b1;
      main_dout   <= '0;
      cpu_din     <= '0;
      cpu_ok      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dsn_lat_reg <= dsn_lat_next;
      main_br     <= br_next;
      main_A      <= a_next;
      main_dsn    <= dsn_next;
      main_rnw    <= rnw_next;
      main_dout   <= dout_next;
      cpu_din     <= din_next;
      cpu_ok      <= ok_next;
      timeout     <= tout_next;
    end
  end

endmodule

// File: tb/tb_jtoutrun_subbus.sv
// Testbench for jtoutrun_subbus. Stimulus pushes the expected completion
// (read data and timeout flag) into a queue; a monitor pops it on every rising
// cpu_ok. Bus-side behaviour is checked directly by the stimulus process.
module tb_jtoutrun_subbus;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs;
  logic [18:0] cpu_A;
  logic [1:0]  cpu_dsn;
  logic        cpu_rnw;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic        cpu_ok;
  logic        timeout;
  logic        main_br;
  logic [18:0] main_A;
  logic [1:0]  main_dsn;
  logic        main_rnw;
  logic [15:0] main_dout;
  logic [15:0] main_din;
  logic        main_ok;

  jtoutrun_subbus dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_A(cpu_A), .cpu_dsn(cpu_dsn), .cpu_rnw(cpu_rnw),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ok(cpu_ok), .timeout(timeout),
    .main_br(main_br), .main_A(main_A), .main_dsn(main_dsn), .main_rnw(main_rnw),
    .main_dout(main_dout), .main_din(main_din), .main_ok(main_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic        tout;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;
  logic prev_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ok(input int bound, output int cycles);
    cycles = 0;
    while (cpu_ok !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
    if (cpu_ok !== 1'b1) begin
      tests++;
      errors++;
      $display("FAIL ack_wait: got no cpu_ok within %0d cycles, required cpu_ok=1", bound);
    end
  endtask

  task automatic push(input logic [15:0] din, input logic tout);
    exp_t e;
    e.din  = din;
    e.tout = tout;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: one line per completed transaction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cpu_ok === 1'b1 && prev_ok !== 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_ack: got cpu_ok=1 din=%h, required no ack", cpu_din);
      end else begin
        e = exp_q.pop_front();
        check("ack_din", 32'(cpu_din), 32'(e.din));
        check("ack_timeout", 32'(timeout), 32'(e.tout));
        $display("[TB] txn done: din=%h timeout=%b (expected %h/%b)", cpu_din, timeout, e.din, e.tout);
      end
    end
    prev_ok = cpu_ok;
  end

  initial begin
    int c;
    rst = 1'b1; cpu_cs = 1'b0; cpu_A = '0; cpu_dsn = 2'b11; cpu_rnw = 1'b1;
    cpu_dout = '0; main_din = '0; main_ok = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    // Reset state
    check("rst_br", 32'(main_br), 0);
    check("rst_dsn", 32'(main_dsn), 32'h3);
    check("rst_rnw", 32'(main_rnw), 1);
    check("rst_A", 32'(main_A), 0);
    check("rst_dout", 32'(main_dout), 0);
    check("rst_din", 32'(cpu_din), 0);
    check("rst_ok", 32'(cpu_ok), 0);
    check("rst_timeout", 32'(timeout), 0);

    // T1: read, grant after 5 cycles, data 1234
    cpu_cs = 1'b1; cpu_A = 19'h12345; cpu_dsn = 2'b00; cpu_rnw = 1'b1;
    push(16'h1234, 1'b0);
    tick();
    check("t1_req_br", 32'(main_br), 1);
    check("t1_req_dsn", 32'(main_dsn), 32'h3);
    check("t1_req_A", 32'(main_A), 32'h12345);
    repeat (5) tick();
    check("t1_wait_dsn", 32'(main_dsn), 32'h3);
    main_ok = 1'b1; main_din = 16'h1234;
    tick();
    check("t1_acc_dsn", 32'(main_dsn), 32'h0);
    wait_ok(50, c);
    check("t1_settle_lat", 32'(c), 3);
    check("t1_done_br", 32'(main_br), 1);
    check("t1_done_dsn", 32'(main_dsn), 32'h3);
    cpu_cs = 1'b0; main_ok = 1'b0; main_din = 16'h0;
    tick();
    check("t1_ok_clear", 32'(cpu_ok), 0);
    check("t1_hold_br", 32'(main_br), 1);

    // T2: byte write 3 cycles after the ack, straight from HOLD
    tick(); tick();
    check("t2_hold_dsn", 32'(main_dsn), 32'h3);
    cpu_cs = 1'b1; cpu_A = 19'h30000; cpu_dsn = 2'b10; cpu_rnw = 1'b0; cpu_dout = 16'hBEEF;
    main_ok = 1'b1;
    push(16'h1234, 1'b0);  // write leaves cpu_din unchanged
    tick();
    check("t2_acc_br", 32'(main_br), 1);
    check("t2_acc_dsn", 32'(main_dsn), 32'h2);
    check("t2_acc_A", 32'(main_A), 32'h30000);
    check("t2_acc_rnw", 32'(main_rnw), 0);
    check("t2_acc_dout", 32'(main_dout), 32'hBEEF);
    wait_ok(50, c);
    check("t2_settle_lat", 32'(c), 3);
    check("t2_done_dsn", 32'(main_dsn), 32'h3);
    check("t2_done_br", 32'(main_br), 1);
    cpu_cs = 1'b0; main_ok = 1'b0;
    tick();
    c = 0;
    while (main_br === 1'b1 && c < 40) begin
      tick();
      c++;
    end
    check("t2_hold_len", 32'(c), 16);
    check("t2_idle_br", 32'(main_br), 0);

    // T3: read, then a new write arriving exactly when the hold expires
    cpu_cs = 1'b1; cpu_A = 19'h00042; cpu_dsn = 2'b01; cpu_rnw = 1'b1;
    main_ok = 1'b1; main_din = 16'h5A5A;
    push(16'h5A5A, 1'b0);
    tick(); tick();
    check("t3_acc_dsn", 32'(main_dsn), 32'h1);
    wait_ok(50, c);
    check("t3_settle_lat", 32'(c), 3);
    cpu_cs = 1'b0; main_ok = 1'b0;
    tick();
    repeat (15) tick();
    check("t3_hold15_br", 32'(main_br), 1);
    cpu_cs = 1'b1; cpu_A = 19'h7FFFF; cpu_dsn = 2'b00; cpu_rnw = 1'b0; cpu_dout = 16'h1111;
    main_ok = 1'b1;
    push(16'h5A5A, 1'b0);
    tick();
    check("t3_race_br", 32'(main_br), 1);
    check("t3_race_dsn", 32'(main_dsn), 32'h0);
    check("t3_race_A", 32'(main_A), 32'h7FFFF);
    wait_ok(50, c);
    cpu_cs = 1'b0; main_ok = 1'b0;
    tick();
    c = 0;
    while (main_br === 1'b1 && c < 40) begin
      tick();
      c++;
    end
    check("t3_idle_br", 32'(main_br), 0);

    // T4: cpu_cs withdrawn while waiting for grant
    cpu_cs = 1'b1; cpu_A = 19'h00010; cpu_rnw = 1'b1; cpu_dsn = 2'b00;
    tick();
    check("t4_req_br", 32'(main_br), 1);
    cpu_cs = 1'b0;
    tick();
    check("t4_abort_br", 32'(main_br), 0);
    tick(); tick();
    check("t4_no_ack", 32'(cpu_ok), 0);

    // T5: grant never comes
    cpu_cs = 1'b1; cpu_A = 19'h00020; cpu_rnw = 1'b1; cpu_dsn = 2'b00;
    push(16'hFFFF, 1'b1);
    tick();
    wait_ok(1100, c);
    check("t5_tout_lat", 32'(c), 1023);
    check("t5_tout_br", 32'(main_br), 0);
    check("t5_tout_din", 32'(cpu_din), 32'hFFFF);
    tick();
    check("t5_pulse_end", 32'(timeout), 0);
    check("t5_ok_held", 32'(cpu_ok), 1);
    cpu_cs = 1'b0;
    tick();
    check("t5_ok_clear", 32'(cpu_ok), 0);
    check("t5_idle_br", 32'(main_br), 0);

    // T6: asynchronous reset in the middle of ACCESS
    cpu_cs = 1'b1; cpu_A = 19'h00001; cpu_dsn = 2'b01; cpu_rnw = 1'b0; cpu_dout = 16'hCAFE;
    main_ok = 1'b1;
    tick(); tick();
    check("t6_acc_dsn", 32'(main_dsn), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_br", 32'(main_br), 0);
    check("t6_rst_dsn", 32'(main_dsn), 32'h3);
    cpu_cs = 1'b0; main_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_post_br", 32'(main_br), 0);
    check("t6_post_ok", 32'(cpu_ok), 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
